uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART serial transmitter, 8N1 framing (1 start, 8 data LSB-first, 1 stop, no parity).
//   Accepts a byte from the calculator/control logic via a start/busy handshake.
//   Serialises the byte onto txd at the rate set by CLKS_PER_BIT.
//   Pairs with the UART receive path to form the full-duplex UART link.
// PARAMETERS
//   CLKS_PER_BIT  16'd434  clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535
// PORTS
//   clk       input   1  system clock; all logic on rising edge
//   n_rst     input   1  asynchronous active-low reset
//   tx_start  input   1  request to send tx_data; sampled only in IDLE
//   tx_data   input   8  byte to transmit; captured on the accepted tx_start cycle
//   txd       output  1  serial line, idle high; registered
//   tx_busy   output  1  high from the cycle after acceptance until the end of the stop bit
//   tx_done   output  1  one-cycle pulse at the end of the stop bit
// BEHAVIOUR
//   Reset (n_rst=0, asynchronous): state=IDLE, txd=1, tx_busy=0, tx_done=0, baud cnt=0,
//     bit idx=0, shift reg=8'h00. Reset mid-frame aborts the frame; txd returns high immediately.
//   State register: 2 bits, IDLE=0, START=1, DATA=2, STOP=3. All outputs are registered.
//   Baud counter: 16 bits. Cleared on every state entry; counts 0..CLKS_PER_BIT-1 in
//     START/DATA/STOP. bit_end = (cnt == CLKS_PER_BIT-1). Wraps to 0 on bit_end.
//   IDLE:  txd=1. If tx_start=1: latch tx_data into shift reg, go to START.
//          txd=0 and tx_busy=1 take effect on the next clock edge (1-cycle latency).
//   START: txd=0 for exactly CLKS_PER_BIT cycles; on bit_end go to DATA with bit idx=0.
//   DATA:  txd=shift[0]; each bit held CLKS_PER_BIT cycles. On bit_end: shift right by 1,
//          bit idx+1. When bit_end occurs with bit idx==7, go to STOP (8 bits total).
//   STOP:  txd=1 for CLKS_PER_BIT cycles. On bit_end: go to IDLE, tx_done=1 for one cycle,
//          tx_busy=0 in that same cycle.
//   Frame length: exactly 10*CLKS_PER_BIT cycles from the first txd=0 cycle to tx_done.
//   Handshake rules:
//     - tx_start while tx_busy=1 is ignored; tx_data changes during a frame have no effect.
//     - tx_start held high continuously produces back-to-back frames.
//     - The next frame's start bit begins 1 cycle after tx_done (the IDLE cycle in which
//       tx_start is sampled), so the line idles high for at least 1 cycle between frames.
//   tx_start asserted in the tx_done cycle is accepted, because state is IDLE in that cycle.
//   No X on outputs at any time after reset; unknown tx_data is only captured when tx_start=1.
// TESTING  (CLKS_PER_BIT=4 unless stated)
//   1. Reset: n_rst low mid-START of frame 0x55 -> txd=1, tx_busy=0, tx_done=0 in the same
//      cycle; after release, line stays idle with no tx_start.
//   2. Single frame 0xA5: pulse tx_start 1 cycle -> txd = 0,1,0,1,0,0,1,0,1,1, each bit
//      held 4 cycles; tx_done pulses once, 40 cycles after txd first goes low.
//   3. Busy ignore: send 0x3C; at cycle 10 assert tx_start with tx_data=0xFF -> the frame
//      still carries 0x3C, only one tx_done, no second frame.
//   4. Back-to-back: hold tx_start=1 with tx_data=0x01 then 0x80 -> two frames, exactly one
//      idle-high cycle between them, payloads decoded LSB-first as 0x01 then 0x80.
//   5. Boundary bytes 0x00 and 0xFF -> 8 data bits all low / all high; stop bit always 1.
//   6. CLKS_PER_BIT=434 with a loopback into the UART receiver at 50 MHz: send 0x00..0xFF
//      -> every byte received intact; frame time 4340 cycles each.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing: one start bit, eight data bits LSB-first, one stop bit.
// A byte is accepted with tx_start while idle, then shifted out on txd at CLKS_PER_BIT
// clock cycles per bit. txd, tx_busy and tx_done all come straight from flops.
module uart_tx #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd434  // clk cycles per serial bit, 2..65535
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;    // cycles elapsed within the current bit
    logic [2:0]  idx_q,   idx_d;    // data bit currently on the line
    logic [7:0]  shift_q, shift_d;  // remaining payload, bit 0 is next out
    logic        txd_q,   txd_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == CLKS_PER_BIT - 16'd1);

    // State register; reset also forces the line back high at once, aborting any frame.
    // NOTE: flops are written with <= so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; registered outputs are derived from the state being entered.
    // NOTE: every signal gets a default first, so no path can leave one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = 16'd0;      // cleared on idle and on every bit boundary / state entry
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level for the cycle after this edge.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4. A driver pushes the expected 10-bit line pattern
// of each accepted byte into a queue; a monitor decodes frames off txd and pops/compares.
module tb_uart_tx;

    localparam logic [15:0] CPB = 16'd4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Expected line pattern: bit i is the i-th bit on the wire (start first, stop last).
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [4];
    logic [9:0] sb [$];

    int n_checks      = 0;
    int n_pass        = 0;
    int cyc           = 0;
    int frames_seen   = 0;
    int last_done_cyc = -1;
    int last_gap      = -1;
    logic prev_done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // tx_done must never stay high two cycles running.
    always @(negedge clk) begin
        if (prev_done === 1'b1) check("done_width", tx_done, 1'b0);
        prev_done = tx_done;
    end

    // Monitor: on a low txd sample, collect 40 samples, then expect tx_done on the next one.
    initial begin : monitor
        logic [9:0] got;
        logic [9:0] exp_fr;
        int lat, hold_bad, flag_bad, start_cyc;
        bit aborted;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && txd === 1'b0) begin
                start_cyc = cyc;
                if (last_done_cyc >= 0) last_gap = start_cyc - last_done_cyc;
                got      = '0;
                got[0]   = txd;
                hold_bad = 0;
                flag_bad = 0;
                aborted  = 1'b0;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (n_rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % 4 == 0) got[k/4] = txd;
                    else if (txd !== got[k/4]) hold_bad++;
                    if (tx_busy !== 1'b1 || tx_done !== 1'b0) flag_bad++;
                end
                if (!aborted) begin
                    lat = -1;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        if (tx_done === 1'b1) begin
                            lat = cyc - start_cyc;
                            break;
                        end
                    end
                    check("done_latency", lat, 40);
                    check("bit_hold", hold_bad, 0);
                    check("busy_during_frame", flag_bad, 0);
                    check("done_cycle_busy", tx_busy, 1'b0);
                    check("done_cycle_txd", txd, 1'b1);
                    last_done_cyc = cyc;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", got, 10'h000);
                    end else begin
                        exp_fr = sb.pop_front();
                        check("frame_bits", got, exp_fr);
                    end
                    frames_seen++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [9:0] fr);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        sb.push_back(fr);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("accept_busy", tx_busy, 1'b1);
        check("accept_txd", txd, 1'b0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int k = 0; k < budget && frames_seen < target; k++) @(negedge clk);
        check("frame_count", frames_seen, target);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int f0, idle_bad, budget;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h55, 10'b1_01010101_0};

        n_rst    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a start bit.
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("midreset_txd", txd, 1'b1);
        check("midreset_busy", tx_busy, 1'b0);
        check("midreset_done", tx_done, 1'b0);
        repeat (2) @(negedge clk);
        sb.delete();
        n_rst = 1'b1;
        f0 = frames_seen;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
        end
        check("idle_after_reset", idle_bad, 0);
        check("no_frame_after_reset", frames_seen, f0);

        // Single frames, including the all-zero and all-one payloads.
        for (int i = 0; i < 4; i++) begin
            f0 = frames_seen;
            send(vecs[i].data, vecs[i].frame);
            wait_frames(f0 + 1, 60);
            repeat (3) @(negedge clk);
        end

        // tx_start with new data during a frame is ignored.
        f0 = frames_seen;
        send(8'h3C, 10'b1_00111100_0);
        repeat (9) @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_frames(f0 + 1, 60);
        repeat (50) @(negedge clk);
        check("busy_ignore_frames", frames_seen, f0 + 1);
        check("busy_ignore_sb_empty", sb.size(), 0);

        // tx_start held high: second byte accepted in the tx_done cycle.
        f0 = frames_seen;
        @(negedge clk);
        tx_data  = 8'h01;
        tx_start = 1'b1;
        sb.push_back(10'b1_00000001_0);
        @(negedge clk);
        tx_data = 8'h80;
        sb.push_back(10'b1_10000000_0);
        budget = 0;
        while (tx_done !== 1'b1 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check("b2b_first_done_seen", tx_done, 1'b1);
        @(negedge clk);
        tx_start = 1'b0;
        wait_frames(f0 + 2, 100);
        check("b2b_gap", last_gap, 1);
        repeat (10) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        check("final_txd_idle", txd, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
